// File: rtl/spi_ram_master.sv
// spi_ram_master: turns byte read/write requests into SPI RAM frames.
// Ports: clk/rst, req_* (valid/ready), rsp_* pulse, SS_n/MOSI/MISO.
module spi_ram_master #(
  parameter int GAP_CYCLES  = 2,
  parameter int TURN_CYCLES = 1,
  parameter int ADDR_CACHE  = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_we,
  input  logic [7:0] req_addr,
  input  logic [7:0] req_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic       SS_n,
  output logic       MOSI,
  input  logic       MISO
);

  localparam int CMAX =
    (GAP_CYCLES > TURN_CYCLES) ?
    GAP_CYCLES : TURN_CYCLES;
  localparam int CW = $clog2(CMAX + 1) + 1;
  localparam logic [CW-1:0] GAP_SAT =
    CW'(GAP_CYCLES);
  localparam logic [CW-1:0] GAP_M1 =
    CW'(GAP_CYCLES - 1);
  localparam logic [CW-1:0] TURN_M1 =
    CW'(TURN_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    AFRAME,
    GAP,
    DFRAME,
    TURN,
    RX,
    RESP
  } state_t;

  state_t state, state_nx;

  logic [3:0]    bit_cnt, bit_cnt_nx;
  logic [CW-1:0] turn_cnt, turn_cnt_nx;
  logic [CW-1:0] hi_cnt;
  logic          a_pend, a_pend_nx;
  logic          we_q;
  logic [7:0]    addr_q, wdata_q;
  logic [10:0]   tx_sh, tx_sh_nx;
  logic [7:0]    rx_sh, rx_sh_nx;
  logic          wr_vld, rd_vld;
  logic [7:0]    last_wr, last_rd;
  logic          ss_n_nx, mosi_nx;
  logic          rsp_valid_nx;
  logic [7:0]    rsp_rdata_nx;

  logic          accept, hit, gap_ok;
  logic          launch, a_done;
  logic          src_we;
  logic [7:0]    src_addr, src_wdata;
  logic [10:0]   a_frame, d_frame;

  assign accept = (state == IDLE) &&
                  req_valid && req_ready;

  // Frame contents must be ready on the
  // accept edge, before fields are captured.
  assign src_we    = accept ? req_we    : we_q;
  assign src_addr  = accept ? req_addr  : addr_q;
  assign src_wdata = accept ? req_wdata : wdata_q;

  assign a_frame = {
    src_we ? 3'b000 : 3'b110, src_addr};
  assign d_frame = src_we ?
    {3'b001, src_wdata} : {3'b111, 8'h00};

  assign hit = (ADDR_CACHE != 0) && (req_we ?
    (wr_vld && (last_wr == req_addr)) :
    (rd_vld && (last_rd == req_addr)));

  // hi_cnt counts SS_n-high cycles before
  // this one; this cycle is high too.
  assign gap_ok = (hi_cnt >= GAP_M1);

  assign a_done = (state == AFRAME) &&
                  (bit_cnt == 4'd10);

  always_comb begin
    state_nx     = state;
    bit_cnt_nx   = bit_cnt;
    turn_cnt_nx  = turn_cnt;
    a_pend_nx    = a_pend;
    tx_sh_nx     = tx_sh;
    rx_sh_nx     = rx_sh;
    ss_n_nx      = 1'b1;
    mosi_nx      = 1'b0;
    rsp_valid_nx = 1'b0;
    rsp_rdata_nx = rsp_rdata;
    launch       = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept) begin
          a_pend_nx = ~hit;
          if (gap_ok) launch = 1'b1;
          else state_nx = GAP;
        end
      end
      AFRAME: begin
        ss_n_nx    = 1'b0;
        mosi_nx    = tx_sh[10];
        tx_sh_nx   = {tx_sh[9:0], 1'b0};
        bit_cnt_nx = bit_cnt + 4'd1;
        if (bit_cnt == 4'd10) begin
          ss_n_nx   = 1'b1;
          mosi_nx   = 1'b0;
          a_pend_nx = 1'b0;
          state_nx  = GAP;
        end
      end
      GAP: begin
        if (gap_ok) launch = 1'b1;
      end
      DFRAME: begin
        ss_n_nx    = 1'b0;
        mosi_nx    = tx_sh[10];
        tx_sh_nx   = {tx_sh[9:0], 1'b0};
        bit_cnt_nx = bit_cnt + 4'd1;
        if (bit_cnt == 4'd10) begin
          mosi_nx = 1'b0;
          if (we_q) begin
            ss_n_nx      = 1'b1;
            state_nx     = RESP;
            rsp_valid_nx = 1'b1;
            rsp_rdata_nx = 8'h00;
          end else if (TURN_CYCLES == 0) begin
            state_nx   = RX;
            bit_cnt_nx = 4'd0;
          end else begin
            state_nx    = TURN;
            turn_cnt_nx = '0;
          end
        end
      end
      TURN: begin
        ss_n_nx     = 1'b0;
        turn_cnt_nx = turn_cnt + 1'b1;
        if (turn_cnt == TURN_M1) begin
          state_nx   = RX;
          bit_cnt_nx = 4'd0;
        end
      end
      RX: begin
        ss_n_nx    = 1'b0;
        rx_sh_nx   = {rx_sh[6:0], MISO};
        bit_cnt_nx = bit_cnt + 4'd1;
        if (bit_cnt == 4'd7) begin
          ss_n_nx      = 1'b1;
          state_nx     = RESP;
          rsp_valid_nx = 1'b1;
          rsp_rdata_nx = {rx_sh[6:0], MISO};
        end
      end
      RESP: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
    // Bit 0 goes out on the launch edge so
    // SS_n falls with valid data.
    if (launch) begin
      ss_n_nx    = 1'b0;
      bit_cnt_nx = 4'd0;
      if (a_pend_nx) begin
        state_nx = AFRAME;
        mosi_nx  = a_frame[10];
        tx_sh_nx = {a_frame[9:0], 1'b0};
      end else begin
        state_nx = DFRAME;
        mosi_nx  = d_frame[10];
        tx_sh_nx = {d_frame[9:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      bit_cnt   <= 4'd0;
      turn_cnt  <= '0;
      a_pend    <= 1'b0;
      tx_sh     <= '0;
      rx_sh     <= '0;
      SS_n      <= 1'b1;
      MOSI      <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= 8'h00;
      req_ready <= 1'b0;
    end else begin
      state     <= state_nx;
      bit_cnt   <= bit_cnt_nx;
      turn_cnt  <= turn_cnt_nx;
      a_pend    <= a_pend_nx;
      tx_sh     <= tx_sh_nx;
      rx_sh     <= rx_sh_nx;
      SS_n      <= ss_n_nx;
      MOSI      <= mosi_nx;
      rsp_valid <= rsp_valid_nx;
      rsp_rdata <= rsp_rdata_nx;
      req_ready <= (state_nx == IDLE);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_q    <= 1'b0;
      addr_q  <= 8'h00;
      wdata_q <= 8'h00;
    end else if (accept) begin
      we_q    <= req_we;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi_cnt <= GAP_SAT;
    end else if (!SS_n) begin
      hi_cnt <= '0;
    end else if (hi_cnt < GAP_SAT) begin
      hi_cnt <= hi_cnt + 1'b1;
    end
  end

  // Cache only trusts an address frame the
  // slave has fully received.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_vld  <= 1'b0;
      rd_vld  <= 1'b0;
      last_wr <= 8'h00;
      last_rd <= 8'h00;
    end else if (a_done) begin
      if (we_q) begin
        wr_vld  <= 1'b1;
        last_wr <= addr_q;
      end else begin
        rd_vld  <= 1'b1;
        last_rd <= addr_q;
      end
    end
  end

endmodule

// File: tb/tb_spi_ram_master.sv
// tb_spi_ram_master: scoreboard bench with SPI slave + RAM model.
// Drives requests, checks responses, frames, latency and gaps.
module tb_spi_ram_master;

  localparam int GAP  = 2;
  localparam int TURN = 1;

  typedef struct {
    logic [7:0] rdata;
    int         acc;
    int         lat;
  } exp_t;

  typedef struct {
    logic [10:0] bits;
    int          len;
    int          gap;
  } frm_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_we = 1'b0;
  logic [7:0] req_addr = 8'h00;
  logic [7:0] req_wdata = 8'h00;
  logic       MISO = 1'b0;
  logic       req_ready;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       SS_n;
  logic       MOSI;

  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  bit   busy = 0;
  int   last_rsp = -100;

  exp_t sb[$];
  frm_t flog[$];

  logic [7:0] emem [256];
  logic [7:0] smem [256];
  bit         m_wv, m_rv;
  logic [7:0] m_wa, m_ra;

  int          s_run = 0;
  int          s_hi = 0;
  int          s_gap = 0;
  logic [10:0] s_sh = '0;
  logic [7:0]  s_wa = 0, s_ra = 0, s_rb = 0;
  bit          s_rd = 0;

  spi_ram_master #(
    .GAP_CYCLES (GAP),
    .TURN_CYCLES(TURN),
    .ADDR_CACHE (1)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_we   (req_we),
    .req_addr (req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata),
    .SS_n     (SS_n),
    .MOSI     (MOSI),
    .MISO     (MISO)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h",
               nm, act, exp);
    end
  endtask

  task automatic chk_frame(input string nm,
                           input logic [10:0] eb,
                           input int el,
                           input int eg);
    frm_t f;
    if (flog.size() == 0) begin
      total++;
      bad++;
      $display("FAIL %s act=none exp=frame", nm);
    end else begin
      f = flog.pop_front();
      chk({nm, "_bits"}, 32'(f.bits), 32'(eb));
      chk({nm, "_len"}, f.len, el);
      if (eg >= 0) chk({nm, "_gap"}, f.gap, eg);
    end
  endtask

  // Slave + RAM: samples MOSI on each rising
  // edge while selected, drives MISO in RX.
  initial begin
    forever begin
      @(posedge clk);
      if (!SS_n) begin
        if (s_run == 0) begin
          s_gap = s_hi;
          s_hi  = 0;
          s_rd  = 0;
        end
        if (s_run < 11) s_sh = {s_sh[9:0], MOSI};
        s_run++;
        if (s_run == 11) begin
          case (s_sh[10:8])
            3'b000: s_wa = s_sh[7:0];
            3'b001: smem[s_wa] = s_sh[7:0];
            3'b110: s_ra = s_sh[7:0];
            3'b111: begin
              s_rb = smem[s_ra];
              s_rd = 1;
            end
            default: ;
          endcase
        end
      end else begin
        if (s_run > 0)
          flog.push_back('{bits: s_sh,
                           len: s_run,
                           gap: s_gap});
        s_run = 0;
        s_hi++;
      end
      #1;
      if (!SS_n && s_rd &&
          s_run >= 11 + TURN &&
          s_run <= 18 + TURN)
        MISO = s_rb[7 - (s_run - 11 - TURN)];
      else
        MISO = 1'b1;
    end
  end

  // Monitor: pops the scoreboard on each
  // response pulse.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (busy) chk("ready_busy", req_ready, 0);
        if (rsp_valid) begin
          if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL rsp_extra act=1 exp=0");
          end else begin
            e = sb.pop_front();
            chk("rsp_rdata", rsp_rdata, e.rdata);
            chk("rsp_lat", cyc - e.acc, e.lat);
          end
          busy = 0;
          last_rsp = cyc;
        end
      end
    end
  end

  task automatic issue(input bit we,
                       input logic [7:0] a,
                       input logic [7:0] d,
                       output int acc);
    int   n;
    bit   hit;
    exp_t e;
    req_we    = we;
    req_addr  = a;
    req_wdata = d;
    req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    acc = cyc;
    if (!req_ready) begin
      total++;
      bad++;
      $display("FAIL accept_timeout act=0 exp=1");
      req_valid = 1'b0;
      return;
    end
    hit = we ? (m_wv && m_wa == a) :
               (m_rv && m_ra == a);
    e.acc = cyc;
    e.lat = we ? 22 + GAP + 1 :
                 22 + GAP + TURN + 8 + 1;
    if (hit) e.lat -= 11 + GAP;
    e.rdata = we ? 8'h00 : emem[a];
    if (we) emem[a] = d;
    if (!hit) begin
      if (we) begin
        m_wv = 1;
        m_wa = a;
      end else begin
        m_rv = 1;
        m_ra = a;
      end
    end
    sb.push_back(e);
    @(posedge clk);
    busy = 1;
    @(negedge clk);
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    req_valid = 1'b0;
    while (sb.size() != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL %s_timeout act=%0d exp=0",
               nm, sb.size());
      sb.delete();
    end
    repeat (3) @(negedge clk);
  endtask

  function automatic int min_gap();
    int m = 1000;
    foreach (flog[i])
      if (flog[i].gap < m) m = flog[i].gap;
    return m;
  endfunction

  initial begin
    #1_500_000;
    $display("FAIL watchdog act=timeout exp=done");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, acc2;
    logic [7:0] a, d;
    for (int i = 0; i < 256; i++) begin
      emem[i] = 8'h00;
      smem[i] = 8'h00;
    end
    m_wv = 0;
    m_rv = 0;
    repeat (3) @(negedge clk);
    chk("rst_ss_n", SS_n, 1);
    chk("rst_mosi", MOSI, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    chk("rst_ready", req_ready, 0);
    rst = 1'b0;
    #1;
    chk("rel_ready0", req_ready, 0);
    @(negedge clk);
    chk("rel_ready1", req_ready, 1);

    // reset in the middle of the data frame
    issue(1, 8'h10, 8'hFF, acc);
    while (cyc - acc < 19) @(negedge clk);
    chk("t1_mid_ss_n", SS_n, 0);
    chk("t1_mid_mosi", MOSI, 1);
    rst = 1'b1;
    #1;
    chk("t1_rst_ss_n", SS_n, 1);
    chk("t1_rst_mosi", MOSI, 0);
    chk("t1_rst_rsp", rsp_valid, 0);
    sb.delete();
    busy = 0;
    emem[8'h10] = 8'h00;
    m_wv = 0;
    m_rv = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("t1_ram_kept", smem[8'h10], 8'h00);
    flog.delete();
    issue(1, 8'h10, 8'h77, acc);
    wait_idle("t1");
    chk_frame("t1_af", {3'b000, 8'h10}, 11, -1);
    chk_frame("t1_df", {3'b001, 8'h77}, 11, GAP);

    // plain write
    flog.delete();
    issue(1, 8'hA5, 8'h3C, acc);
    wait_idle("t2");
    chk_frame("t2_af", {3'b000, 8'hA5}, 11, -1);
    chk_frame("t2_df", {3'b001, 8'h3C}, 11, GAP);
    chk("t2_ram", smem[8'hA5], 8'h3C);

    // read, address frame issued
    flog.delete();
    issue(0, 8'hA5, 8'h00, acc);
    wait_idle("t3");
    chk_frame("t3_af", {3'b110, 8'hA5}, 11, -1);
    chk_frame("t3_df", {3'b111, 8'h00},
              11 + TURN + 8, GAP);

    // read again, address cached
    flog.delete();
    issue(0, 8'hA5, 8'h00, acc);
    wait_idle("t4");
    chk("t4_nframes", flog.size(), 1);
    chk_frame("t4_df", {3'b111, 8'h00},
              11 + TURN + 8, -1);

    // back-to-back writes, req_valid held
    flog.delete();
    issue(1, 8'h20, 8'h11, acc);
    issue(1, 8'h21, 8'h22, acc2);
    chk("t5_b2b_accept", acc2, last_rsp + 1);
    wait_idle("t5");
    chk("t5_nframes", flog.size(), 4);
    chk("t5_gap", min_gap() >= GAP, 1);
    chk("t5_ram0", smem[8'h20], 8'h11);
    chk("t5_ram1", smem[8'h21], 8'h22);

    // random write/read pairs
    flog.delete();
    for (int i = 0; i < 1000; i++) begin
      a = 8'($urandom_range(0, 15));
      d = 8'($urandom_range(0, 255));
      issue(1, a, d, acc);
      issue(0, a, 8'($urandom_range(0, 255)),
            acc);
    end
    wait_idle("t6");
    chk("t6_gap", min_gap() >= GAP, 1);

    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end

endmodule

// File: doc/spi_ram_master.md
Name: spi_ram_master

Overview:
Host-side SPI master that sequences byte read/write requests into the opcode frames our spi slave/RAM block accepts.
- Write: write-address frame, then write-data frame.
- Read: read-address frame, then read-data frame, then MISO capture.
- Sits between an internal requester (valid/ready) and the spi pins. Runs on the same clk as the slave; no separate SCLK.

Parameters:
GAP_CYCLES, 2, SS_n-high cycles between consecutive frames (min 1).
TURN_CYCLES, 1, SS_n-low cycles after read-data frame before first MISO sample (min 0).
ADDR_CACHE, 1, 1 = skip the address frame when the address equals the last one sent for that direction.

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  asynchronous reset, active-high
req_valid  input  1  request present
req_ready  output  1  master can accept request this cycle
req_we  input  1  1 = write, 0 = read
req_addr  input  8  RAM address
req_wdata  input  8  write data
rsp_valid  output  1  one-cycle completion pulse (reads and writes)
rsp_rdata  output  8  read data, valid with rsp_valid; 0 for writes
SS_n  output  1  slave select, active-low
MOSI  output  1  serial data to slave, MSB first
MISO  input  1  serial data from slave

Behaviour:
- Reset (async, any state): state=IDLE, SS_n=1, MOSI=0, req_ready=0 for one cycle after release then 1, rsp_valid=0, rsp_rdata=0, both address caches invalid. A frame cut by reset is abandoned; the slave sees SS_n rise.
- Outputs SS_n, MOSI, rsp_* are registered. The slave samples MOSI on the rising edge after it is driven.
- Handshake: request accepted when req_valid && req_ready in IDLE. Fields captured; req_ready=0 until the cycle after rsp_valid.
- Frame = 11 consecutive cycles with SS_n=0:
  - 3 opcode bits, then 8 payload bits, MSB first.
  - Opcodes: 000 write-addr, 001 write-data, 110 read-addr, 111 read-data.
  - SS_n returns to 1 the cycle after bit 10.
- States: IDLE -> AFRAME -> GAP -> DFRAME -> (write: RESP | read: TURN -> RX -> RESP) -> IDLE.
  - AFRAME: opcode 000 (write) or 110 (read) + req_addr.
  - GAP: SS_n=1, MOSI=0 for GAP_CYCLES.
  - DFRAME: opcode 001 + req_wdata, or 111 + 8 dummy zero bits.
  - TURN: SS_n=0, MOSI=0 for TURN_CYCLES; skipped when 0.
  - RX: SS_n=0; sample MISO for 8 cycles into shift register, MSB first. SS_n=1 afterwards.
  - RESP: rsp_valid=1 for exactly one cycle; rsp_rdata = shift register (read) or 0 (write).
- Bit counter: 4 bits, counts 0..10 in frames, 0..7 in RX. GAP/TURN counter sized from max parameter.
- Address cache (ADDR_CACHE=1):
  - Separate last_wr_addr/last_rd_addr, each with a valid bit.
  - On a hit, IDLE goes directly to DFRAME; no AFRAME, no leading GAP.
  - Cache updated at end of a completed AFRAME only.
  - ADDR_CACHE=0: AFRAME always issued.
- Latency, accept cycle = 0, no cache hit:
  - Write: rsp_valid at cycle 22+GAP_CYCLES+1.
  - Read: rsp_valid at cycle 22+GAP_CYCLES+TURN_CYCLES+8+1.
  - Cache hit removes 11+GAP_CYCLES.
- Back-to-back: the next request may be accepted the cycle after rsp_valid. A GAP_CYCLES idle of SS_n=1 is enforced before the next frame starts.
- req_valid with other fields changing while busy: ignored; captured fields are used.
- MISO is ignored outside RX.

Test Plan:
1. Reset mid-DFRAME (assert rst at bit 5) -> SS_n=1, MOSI=0, rsp_valid=0 immediately. After release, a write to 0x10 issues AFRAME again (cache invalid).
2. Write addr=0xA5, data=0x3C, GAP=2 -> MOSI stream 000_10100101, 2 gap cycles, 001_00111100. SS_n low exactly 11 cycles per frame. rsp_valid at cycle 25 with rsp_rdata=0.
3. Read addr=0xA5 after step 2, slave model returns 0x3C -> frames 110_10100101 and 111_00000000, 1 turn cycle, 8 RX cycles. rsp_rdata=0x3C.
4. Second read of 0xA5 with ADDR_CACHE=1 -> no 110 frame. First SS_n fall carries opcode 111. Latency reduced by 13 cycles. Same data returned.
5. Two writes issued with req_valid held high -> second accepted the cycle after the first rsp_valid. SS_n high ≥2 cycles between transactions. Slave RAM holds both values.
6. 1000 random write/read pairs against the slave+RAM model -> all read data matches; no req_ready=1 while busy.
